// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults, divisor type and index-width helper for the tick generator.
package tick_gen_pkg;
    localparam int unsigned DEFAULT_WIDTH         = 28;
    localparam int unsigned DEFAULT_RESET_DIVISOR = 200_000_000;

    typedef logic [DEFAULT_WIDTH-1:0] divisor_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tick_channel.sv
// tick_channel: one divider channel with a shadowed divisor applied at the period boundary.
// The Square toggle flop is built only when TICK_GEN_TOGGLE_EN is defined.
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned RESET_DIVISOR = DEFAULT_RESET_DIVISOR
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_div_i,
    output logic             tick_o,
    output logic             square_o,
    output logic             pend_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d, div_q, div_d, shd_q, shd_d;
    logic             pend_q, pend_d, tick_q, tick_d, apply;

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        shd_d  = load_i ? load_div_i : shd_q;
        pend_d = pend_q;
        tick_d = 1'b0;
        apply  = 1'b0;
        if (sync_i) begin
            cnt_d  = '0;
            div_d  = load_i ? load_div_i : (pend_q ? shd_q : div_q);
            pend_d = 1'b0;
        end else begin
            // A halted or paused channel takes a pending divisor at once; a running one waits for its wrap.
            if (div_q == '0) begin
                cnt_d = '0;
                apply = pend_q;
            end else if (!en_i) begin
                cnt_d = pend_q ? '0 : cnt_q;
                apply = pend_q;
            end else if (cnt_q == div_q - WIDTH'(1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                apply  = pend_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            div_d  = apply ? shd_q : div_q;
            pend_d = load_i | (pend_q & ~apply);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            div_q  <= WIDTH'(RESET_DIVISOR);
            shd_q  <= '0;
            pend_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
        end
    end

`ifdef TICK_GEN_TOGGLE_EN
    logic sq_q, sq_d;

    assign sq_d = sync_i ? 1'b0 : sq_q ^ tick_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sq_q <= 1'b0;
        else         sq_q <= sq_d;
    end

    assign square_o = sq_q;
`else
    assign square_o = 1'b0;
`endif

    assign tick_o = tick_q;
    assign pend_o = pend_q;
endmodule

// File: rtl/tick_generator.sv
// tick_generator: multi-channel programmable tick generator with run-time divisor reload.
// Define TICK_GEN_TOGGLE_EN to build the per-channel Square toggle outputs.
module tick_generator
    import tick_gen_pkg::*;
#(
    parameter  int unsigned CHANNELS      = 3,
    parameter  int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter  int unsigned RESET_DIVISOR = DEFAULT_RESET_DIVISOR,
    localparam int unsigned IDXW          = idx_width(CHANNELS)
) (
    input  logic                MasterClock,
    input  logic                ResetN,
    input  logic [CHANNELS-1:0] Enable,
    input  logic                Sync,
    input  logic                LoadValid,
    input  logic [IDXW-1:0]     LoadChannel,
    input  logic [WIDTH-1:0]    LoadDivisor,
    output logic [CHANNELS-1:0] Tick,
    output logic [CHANNELS-1:0] Square,
    output logic [CHANNELS-1:0] Pending
);
    logic [CHANNELS-1:0] load;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Out-of-range channel indices match no strobe and are dropped.
        assign load[i] = LoadValid && (LoadChannel == IDXW'(i));

        tick_channel #(
            .WIDTH        (WIDTH),
            .RESET_DIVISOR(RESET_DIVISOR)
        ) u_ch (
            .clk_i     (MasterClock),
            .rst_ni    (ResetN),
            .en_i      (Enable[i]),
            .sync_i    (Sync),
            .load_i    (load[i]),
            .load_div_i(LoadDivisor),
            .tick_o    (Tick[i]),
            .square_o  (Square[i]),
            .pend_o    (Pending[i])
        );
    end
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: table-driven, scoreboarded check of a 3-channel tick_generator with RESET_DIVISOR 4.
module tb_tick_generator;
    localparam int CH = 3;
    localparam int W  = 8;
`ifdef TICK_GEN_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] en = '0;
    logic          sync = 1'b0;
    logic          lv = 1'b0;
    logic [1:0]    lch = '0;
    logic [W-1:0]  ldiv = '0;
    logic [CH-1:0] tick, square, pend;

    typedef struct {
        logic [2:0] en;
        logic       sync;
        logic       lv;
        logic [1:0] lch;
        logic [7:0] ldiv;
        logic [2:0] tick;
        logic [2:0] pend;
    } vec_t;

    typedef struct {
        logic [2:0] tick;
        logic [2:0] pend;
        logic [2:0] sq;
    } exp_t;

    vec_t       tbl[40];
    exp_t       sb[$];
    logic [2:0] sq_m = '0;
    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;

    tick_generator #(.CHANNELS(CH), .WIDTH(W), .RESET_DIVISOR(4)) dut (
        .MasterClock(clk),
        .ResetN     (rst_n),
        .Enable     (en),
        .Sync       (sync),
        .LoadValid  (lv),
        .LoadChannel(lch),
        .LoadDivisor(ldiv),
        .Tick       (tick),
        .Square     (square),
        .Pending    (pend)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int e, int s, int l, int c, int d, int t, int p);
        vec_t v;
        v.en   = 3'(e);
        v.sync = 1'(s);
        v.lv   = 1'(l);
        v.lch  = 2'(c);
        v.ldiv = 8'(d);
        v.tick = 3'(t);
        v.pend = 3'(p);
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %b expected %b", nm, edge_n, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        en   = v.en;
        sync = v.sync;
        lv   = v.lv;
        lch  = v.lch;
        ldiv = v.ldiv;
        sq_m = v.sync ? 3'b000 : sq_m ^ v.tick;
        e.tick = v.tick;
        e.pend = v.pend;
        e.sq   = TOG ? sq_m : 3'b000;
        sb.push_back(e);
        @(posedge clk);
        #1;
        edge_n++;
        e = sb.pop_front();
        cmp("tick", tick, e.tick);
        cmp("pending", pend, e.pend);
        cmp("square", square, e.sq);
    endtask

    task automatic idle(input int n, input int last_tick);
        for (int i = 0; i < n - 1; i++) step(mk('b111, 0, 0, 0, 0, 0, 0));
        step(mk('b111, 0, 0, 0, 0, last_tick, 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 40; i++) tbl[i] = mk('b111, 0, 0, 0, 0, 0, 0);
        tbl[3].tick  = 3'b111;
        tbl[7].tick  = 3'b111;
        tbl[11].tick = 3'b111;
        tbl[13] = mk('b111, 0, 1, 1, 2, 'b000, 'b010);
        tbl[14].pend = 3'b010;
        tbl[15].tick = 3'b111;
        tbl[17].tick = 3'b010;
        tbl[19].tick = 3'b111;
        tbl[21].tick = 3'b010;
        tbl[23] = mk('b111, 0, 1, 0, 3, 'b111, 'b001);
        tbl[24].pend = 3'b001;
        tbl[25].tick = 3'b010;
        tbl[25].pend = 3'b001;
        tbl[26].pend = 3'b001;
        tbl[27].tick = 3'b111;
        tbl[28] = mk('b111, 0, 1, 2, 5, 'b000, 'b100);
        tbl[29] = mk('b111, 0, 1, 2, 7, 'b010, 'b100);
        tbl[30].tick = 3'b001;
        tbl[30].pend = 3'b100;
        tbl[31].tick = 3'b110;
        tbl[33].tick = 3'b011;
        tbl[35].tick = 3'b010;
        tbl[36].tick = 3'b001;
        tbl[37].tick = 3'b010;
        tbl[38].tick = 3'b100;
        tbl[39].tick = 3'b011;

        #2;
        cmp("reset tick", tick, 3'b000);
        cmp("reset pending", pend, 3'b000);
        cmp("reset square", square, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset period, mid-period reload, reload at wrap, last-load-wins
        for (int i = 0; i < 40; i++) step(tbl[i]);

        // Loads of 6 at differing phases, then Sync aligns everything
        step(mk('b111, 0, 1, 0, 6, 'b000, 'b001));
        step(mk('b111, 0, 1, 1, 6, 'b010, 'b011));
        step(mk('b111, 0, 1, 2, 6, 'b001, 'b110));
        step(mk('b111, 1, 0, 0, 0, 'b000, 'b000));
        idle(6, 'b111);

        // Sync with simultaneous load of 2 on channel 0
        step(mk('b111, 1, 1, 0, 2, 'b000, 'b000));
        idle(2, 'b001);
        idle(2, 'b001);
        idle(2, 'b111);

        // Pause channel 0 for 3 cycles at cnt=2 with D=5
        step(mk('b111, 1, 1, 0, 5, 'b000, 'b000));
        idle(2, 'b000);
        for (int i = 0; i < 3; i++) step(mk('b110, 0, 0, 0, 0, 'b000, 'b000));
        step(mk('b111, 0, 0, 0, 0, 'b110, 'b000));
        idle(2, 'b001);
        idle(2, 'b000);
        // Load during a pause applies immediately and restarts the count
        step(mk('b110, 0, 1, 0, 5, 'b000, 'b001));
        step(mk('b110, 0, 0, 0, 0, 'b110, 'b000));
        idle(5, 'b001);

        // Sync overrides the wrap of channels 1 and 2
        step(mk('b111, 1, 0, 0, 0, 'b000, 'b000));
        // Halt channel 1 after its current wrap
        step(mk('b111, 0, 1, 1, 0, 'b000, 'b010));
        for (int i = 0; i < 3; i++) step(mk('b111, 0, 0, 0, 0, 'b000, 'b010));
        step(mk('b111, 0, 0, 0, 0, 'b001, 'b010));
        step(mk('b111, 0, 0, 0, 0, 'b110, 'b000));
        idle(4, 'b001);
        idle(2, 'b100);
        // Divisor 1 on the halted channel: applied next cycle, then continuous ticks
        step(mk('b111, 0, 1, 1, 1, 'b000, 'b010));
        step(mk('b111, 0, 0, 0, 0, 'b000, 'b000));
        step(mk('b111, 0, 0, 0, 0, 'b011, 'b000));
        step(mk('b111, 0, 0, 0, 0, 'b010, 'b000));
        step(mk('b111, 0, 0, 0, 0, 'b010, 'b000));
        step(mk('b111, 0, 0, 0, 0, 'b110, 'b000));
        // Out-of-range channel index is ignored
        step(mk('b111, 0, 1, 3, 2, 'b010, 'b000));
        step(mk('b111, 0, 0, 0, 0, 'b011, 'b000));
        step(mk('b111, 0, 0, 0, 0, 'b010, 'b000));

        // Asynchronous reset mid-count drops outputs at once
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async reset tick", tick, 3'b000);
        cmp("async reset pending", pend, 3'b000);
        cmp("async reset square", square, 3'b000);
        sq_m = '0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
        idle(4, 'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tick_generator.md
# tick_generator

Multi-channel programmable tick generator; parametrised successor to the fixed-breakpoint clock divider. Each channel produces a one-cycle `Tick` pulse every `D` MasterClock cycles. `D` is reloadable at run time and applied glitch-free at the period boundary. Channels have per-channel pause/enable, a global phase-alignment `Sync`, and an optional square-wave output. It feeds game-step, display-scan and animation timing from one counter bank.

## Interface
- `CHANNELS`, default 3: number of independent channels, ≥1.
- `WIDTH`, default 28: divisor/counter width in bits.
- `RESET_DIVISOR`, default 200000000: divisor loaded into every channel at reset; must fit `WIDTH`.
- `IDXW`, derived: max($clog2(CHANNELS),1). Localparam, not overridable.

Ports:
- `MasterClock`  in  1: sole clock, rising edge.
- `ResetN`  in  1: asynchronous, active-low reset.
- `Enable`  in  CHANNELS: per-channel run; low pauses that channel.
- `Sync`  in  1: single-cycle pulse; restarts phase of all channels.
- `LoadValid`  in  1: divisor write strobe, always accepted.
- `LoadChannel`  in  IDXW: target channel index.
- `LoadDivisor`  in  WIDTH: new divisor; 0 = halt.
- `Tick`  out  CHANNELS: registered one-cycle pulses.
- `Square`  out  CHANNELS: registered toggle output (see Configuration).
- `Pending`  out  CHANNELS: high while a loaded divisor awaits application.

## Operation
- Per channel state: counter `cnt`, active divisor `div`, shadow divisor `shd`, flag `pend`.
- Enabled cycle with `div`≠0:
  - If `cnt == div-1`: `cnt`←0, `Tick`←1, and if `pend` then `div`←`shd`, `pend`←0.
  - Else: `cnt`←`cnt+1`, `Tick`←0.
- `div`=0: channel halted. `cnt` holds 0, `Tick` is 0. A pending load applies on the next cycle regardless of `Enable`.
- `Enable` low: `cnt` holds, `Tick`←0, and a pending load applies immediately with `cnt`←0.
- Load with `LoadValid` high:
  - Writes `shd`←`LoadDivisor` and sets `pend` for `LoadChannel`.
  - Back-to-back loads before application: last value wins.
  - `LoadChannel` ≥ CHANNELS: write ignored.
- Load in the same cycle as that channel's wrap: the wrap uses the old `div`. The new value is stored pending and applies at the following wrap.
- `Sync` high, on all channels:
  - `cnt`←0, `Tick`←0, `Square`←0.
  - Any pending value is applied, including one written in the same cycle.
  - `Sync` overrides the wrap.
- `Enable` has no effect on `Sync` handling.
- Arithmetic:
  - Unsigned; `cnt` never exceeds `div-1`.
  - `div`=1 gives `Tick` high every enabled cycle.

## Timing
- Reset values (asynchronous, while `ResetN` low):
  - `cnt`=0, `div`=RESET_DIVISOR, `shd`=0, `pend`=0.
  - `Tick`=0, `Square`=0, `Pending`=0.
- `Tick` latency: first high after the D-th enabled rising edge following reset/Sync/apply. Thereafter it is high for exactly 1 cycle every D enabled cycles.
- `Pending` rises the edge after `LoadValid` and falls on the edge that applies the value.
- Pausing stretches the period by the number of disabled cycles; phase is retained.
- Reset mid-period: all outputs drop immediately (asynchronous). Counting resumes on the first edge after `ResetN` deasserts.

## Configuration
- `TICK_GEN_TOGGLE_EN` defined: `Square[i]` toggles on every cycle `Tick[i]` is asserted. This gives a 50% duty wave of period 2·D, cleared by reset and `Sync`.
- Undefined: `Square` is tied to 0 and the toggle flops are not built.

## Structure
- Package `tick_gen_pkg`: default `WIDTH`/`RESET_DIVISOR` constants and the `divisor_t` typedef (logic [WIDTH-1:0]).
- Sub-module `tick_channel`:
  - Holds one channel's `cnt`/`div`/`shd`/`pend`/`Tick`/`Square` logic.
  - Top decodes `LoadChannel` into per-channel load strobes and instantiates CHANNELS copies.

## Test plan
- Reset with RESET_DIVISOR overridden to 4, all enabled → each `Tick` high after edges 4, 8, 12; `Square` (macro on) toggles at the same edges.
- Channel 1 at D=4; load D=2 at mid-period (cnt=1) → `Pending[1]` high; next tick still 4 cycles after the previous one, then ticks every 2 cycles with `Pending` low.
- Load D=3 on the exact wrap cycle → that wrap uses the old D; the next period is the old D; D=3 applies after it. Two loads (5, then 7) before the wrap → 7 applied.
- Drop `Enable[0]` for 3 cycles at cnt=2 with D=5 → tick delayed by 3 cycles; load during pause applies immediately and the next tick comes 5 enabled cycles later.
- `Sync` with channels at different phases, D=6 on all → all `Tick` coincide 6 edges later. `Sync` with a simultaneous load of D=2 to channel 0 → channel 0 ticks 2 edges later.
- Load D=0 → halt after the current wrap, `Tick`=0 indefinitely. Load D=1 → `Tick` continuously high. `LoadChannel`=CHANNELS → no state change. Assert `ResetN` mid-count → outputs 0 immediately.
